cordic_sched: RTL

//  Round-robin scheduler and sequencer for the shared cordic_data datapath.

---
 rtl/cordic_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cordic_sched.sv
// Round-robin scheduler/sequencer for the shared cordic_data datapath:
// arbitrates requesters, steps the datapath from its dir feedback, returns tagged results.
module cordic_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_mode,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_angle,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_y,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [BIT_WIDTH-1:0]           rsp_angle,
  output logic [BIT_WIDTH-1:0]           rsp_x,
  output logic [BIT_WIDTH-1:0]           rsp_y,
  output logic                           busy,
  output logic                           dp_load_regs,
  output logic                           dp_add,
  output logic                           dp_sub,
  output logic                           dp_iter,
  output logic                           dp_mode,
  output logic [BIT_WIDTH-1:0]           dp_in_angle,
  output logic [BIT_WIDTH-1:0]           dp_in_x,
  output logic [BIT_WIDTH-1:0]           dp_in_y,
  input  logic                           dp_reached_target,
  input  logic                           dp_dir,
  input  logic [BIT_WIDTH-1:0]           dp_out_angle,
  input  logic [BIT_WIDTH-1:0]           dp_out_x,
  input  logic [BIT_WIDTH-1:0]           dp_out_y
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ITER, RESP} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] rr_last, grant_q, winner, cand;
  logic            mode_q, any_valid;

  // Search upward from the last winner with wrap; the first hit wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_last) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    rsp_id       = '0;
    rsp_angle    = '0;
    rsp_x        = '0;
    rsp_y        = '0;
    busy         = 1'b0;
    dp_load_regs = 1'b0;
    dp_add       = 1'b0;
    dp_sub       = 1'b0;
    dp_iter      = 1'b0;
    dp_mode      = 1'b0;
    dp_in_angle  = '0;
    dp_in_x      = '0;
    dp_in_y      = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready    = NUM_REQ'(1) << winner;
          dp_load_regs = 1'b1;
          dp_mode      = req_mode[winner];
          dp_in_angle  = req_angle[winner*BIT_WIDTH +: BIT_WIDTH];
          dp_in_x      = req_x[winner*BIT_WIDTH +: BIT_WIDTH];
          dp_in_y      = req_y[winner*BIT_WIDTH +: BIT_WIDTH];
          state_nx     = ITER;
        end
      end
      ITER: begin
        busy    = 1'b1;
        dp_mode = mode_q;
        dp_add  = dp_dir;
        dp_sub  = ~dp_dir;
        if (dp_reached_target) state_nx = RESP;
        else                   dp_iter  = 1'b1;
      end
      RESP: begin
        busy      = 1'b1;
        dp_mode   = mode_q;
        rsp_valid = 1'b1;
        rsp_id    = grant_q;
        rsp_angle = dp_out_angle;
        rsp_x     = dp_out_x;
        rsp_y     = dp_out_y;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= ID_W'(NUM_REQ - 1);
      mode_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_valid) begin
        grant_q <= winner;
        rr_last <= winner;
        mode_q  <= req_mode[winner];
      end
    end
  end

endmodule
